// File: rtl/cpu_dbus_bridge_pkg.sv
// cpu_dbus_bridge_pkg: shared bus widths, FSM states and posted-write entry layout.
package cpu_dbus_bridge_pkg;

  localparam int unsigned BUS_AW  = 32;
  localparam int unsigned BUS_DW  = 32;
  localparam int unsigned BUS_BEW = 4;
  localparam int unsigned WORD_AW = BUS_AW - 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_READ,
    ST_WRITE
  } dbus_state_e;

  // Posted write entry {be, word addr, wdata} = 4+30+32 bits
  typedef struct packed {
    logic [BUS_BEW-1:0] be;
    logic [WORD_AW-1:0] addr;
    logic [BUS_DW-1:0]  wdata;
  } wbuf_entry_t;

endpackage

// File: rtl/dbus_wbuf_fifo.sv
// dbus_wbuf_fifo: synchronous posted-write FIFO, head visible combinationally.
// Only compiled when DBUS_WBUF_EN is defined.
`ifdef DBUS_WBUF_EN
module dbus_wbuf_fifo
  import cpu_dbus_bridge_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_push,
  input  wbuf_entry_t i_data,
  input  logic        i_pop,
  output wbuf_entry_t o_head,
  output logic        o_full,
  output logic        o_empty
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [PW:0] wr_ptr;
  logic [PW:0] rd_ptr;
  wbuf_entry_t mem [DEPTH];

  // Pointers carry one extra wrap bit to tell full from empty
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (i_push) wr_ptr <= wr_ptr + {{PW{1'b0}}, 1'b1};
      if (i_pop)  rd_ptr <= rd_ptr + {{PW{1'b0}}, 1'b1};
    end
  end

  // Storage write
  always_ff @(posedge i_clk) begin
    if (i_push) mem[wr_ptr[PW-1:0]] <= i_data;
  end

  // Head and status flags
  always_comb begin
    o_head  = mem[rd_ptr[PW-1:0]];
    o_empty = (wr_ptr == rd_ptr);
    o_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  end

endmodule
`endif

// File: rtl/cpu_dbus_bridge.sv
// cpu_dbus_bridge: turns single-cycle cpu data accesses into held req/ack bus
// transactions, stalling the cpu via o_clk_ce. Define DBUS_WBUF_EN to enable the
// posted-write FIFO (WBUF_DEPTH entries) so stores retire without stalling.
module cpu_dbus_bridge
  import cpu_dbus_bridge_pkg::*;
#(
  parameter int unsigned WBUF_DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_addr_d,
  input  logic [31:0] i_data_wr_d,
  input  logic [3:0]  i_wr_d,
  input  logic        i_rd_d,
  output logic [31:0] o_data_rd_d,
  output logic        o_clk_ce,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [3:0]  o_mem_be,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata
);

  dbus_state_e        state;
  dbus_state_e        state_nxt;
  logic [WORD_AW-1:0] lat_addr;
  logic               has_wr;
  logic               has_rd;
  logic               unused_addr_lsb;

  // A store with a simultaneous read is a plain store
  assign has_wr          = |i_wr_d;
  assign has_rd          = i_rd_d & ~has_wr;
  assign unused_addr_lsb = ^i_addr_d[1:0];

  if ((WBUF_DEPTH < 2) || ((WBUF_DEPTH & (WBUF_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("WBUF_DEPTH must be a power of 2 and at least 2");
  end

`ifdef DBUS_WBUF_EN
  wbuf_entry_t fifo_in;
  wbuf_entry_t fifo_head;
  logic        fifo_push;
  logic        fifo_pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic        bus_wr_req;

  // Pack the cpu store into a FIFO entry
  always_comb begin
    fifo_in.be    = i_wr_d;
    fifo_in.addr  = i_addr_d[BUS_AW-1:2];
    fifo_in.wdata = i_data_wr_d;
  end

  // A pop on this edge frees a slot, so a full FIFO can accept in the same cycle
  assign bus_wr_req = ~fifo_empty & (state != ST_READ);
  assign fifo_pop   = bus_wr_req & i_mem_ack;
  assign o_clk_ce   = (state == ST_IDLE) & (~fifo_full | fifo_pop);
  assign fifo_push  = o_clk_ce & has_wr;

  dbus_wbuf_fifo #(.DEPTH(WBUF_DEPTH)) u_wbuf (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (fifo_push),
    .i_data  (fifo_in),
    .i_pop   (fifo_pop),
    .o_head  (fifo_head),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  // Capture the read address at accept
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)               lat_addr <= '0;
    else if (o_clk_ce & has_rd) lat_addr <= i_addr_d[BUS_AW-1:2];
  end

  // Reads wait in DRAIN until every buffered store has reached the bus
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (o_clk_ce & has_rd) state_nxt = fifo_empty ? ST_READ : ST_DRAIN;
      ST_DRAIN: if (fifo_empty) state_nxt = ST_READ;
      ST_READ:  if (i_mem_ack) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Bus drive: pending read owns the bus, otherwise the FIFO head
  always_comb begin
    o_mem_req   = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_be    = '0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (state == ST_READ) begin
      o_mem_req  = 1'b1;
      o_mem_be   = '1;
      o_mem_addr = {lat_addr, 2'b00};
    end else if (bus_wr_req) begin
      o_mem_req   = 1'b1;
      o_mem_we    = 1'b1;
      o_mem_be    = fifo_head.be;
      o_mem_addr  = {fifo_head.addr, 2'b00};
      o_mem_wdata = fifo_head.wdata;
    end
  end
`else
  logic [BUS_BEW-1:0] lat_be;
  logic [BUS_DW-1:0]  lat_wdata;

  assign o_clk_ce = (state == ST_IDLE);

  // Capture the access at accept
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lat_addr  <= '0;
      lat_be    <= '0;
      lat_wdata <= '0;
    end else if (o_clk_ce & (has_rd | has_wr)) begin
      lat_addr  <= i_addr_d[BUS_AW-1:2];
      lat_be    <= i_wr_d;
      lat_wdata <= i_data_wr_d;
    end
  end

  // Every access stalls until its ack
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (o_clk_ce & has_wr)      state_nxt = ST_WRITE;
        else if (o_clk_ce & has_rd) state_nxt = ST_READ;
      end
      ST_READ, ST_WRITE: if (i_mem_ack) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Bus drive from the captured access
  always_comb begin
    o_mem_req   = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_be    = '0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (state == ST_READ) begin
      o_mem_req  = 1'b1;
      o_mem_be   = '1;
      o_mem_addr = {lat_addr, 2'b00};
    end else if (state == ST_WRITE) begin
      o_mem_req   = 1'b1;
      o_mem_we    = 1'b1;
      o_mem_be    = lat_be;
      o_mem_addr  = {lat_addr, 2'b00};
      o_mem_wdata = lat_wdata;
    end
  end
`endif

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Read data captured at the read ack, held until the next read completes
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                          o_data_rd_d <= '0;
    else if (state == ST_READ && i_mem_ack) o_data_rd_d <= i_mem_rdata;
  end

endmodule

// File: tb/tb_cpu_dbus_bridge.sv
// tb_cpu_dbus_bridge: directed plus randomized accesses against a reference memory
// model and an expected bus-transaction queue.
module tb_cpu_dbus_bridge;

  localparam int unsigned DEPTH  = 4;
  localparam int          BUDGET = 200;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [31:0] i_addr_d = '0;
  logic [31:0] i_data_wr_d = '0;
  logic [3:0]  i_wr_d = '0;
  logic        i_rd_d = 1'b0;
  logic [31:0] o_data_rd_d;
  logic        o_clk_ce;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [3:0]  o_mem_be;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic        i_mem_ack = 1'b0;
  logic [31:0] i_mem_rdata = '0;

  always #5 i_clk = ~i_clk;

  cpu_dbus_bridge #(.WBUF_DEPTH(DEPTH)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_addr_d    (i_addr_d),
    .i_data_wr_d (i_data_wr_d),
    .i_wr_d      (i_wr_d),
    .i_rd_d      (i_rd_d),
    .o_data_rd_d (o_data_rd_d),
    .o_clk_ce    (o_clk_ce),
    .o_mem_req   (o_mem_req),
    .o_mem_we    (o_mem_we),
    .o_mem_be    (o_mem_be),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .i_mem_ack   (i_mem_ack),
    .i_mem_rdata (i_mem_rdata)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  typedef struct {
    bit          we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t        exp_q[$];
  logic [31:0] smem [logic [29:0]];
  logic [31:0] rmem [logic [29:0]];
  int          slave_wait = -1;
  bit          slave_hold = 1'b0;
  int          last_wait = 0;
  int          pend_wr = 0;
  logic [31:0] last_rd = '0;

  function automatic logic [31:0] mem_init(input logic [29:0] w);
    return ({2'b00, w} * 32'h9E3779B1) ^ 32'hA5A50F0F;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] smem_rd(input logic [29:0] w);
    return smem.exists(w) ? smem[w] : mem_init(w);
  endfunction

  function automatic logic [31:0] rmem_rd(input logic [29:0] w);
    return rmem.exists(w) ? rmem[w] : mem_init(w);
  endfunction

  // Bus slave: random or fixed wait states, stability and ordering checks
  initial begin
    txn_t cur;
    txn_t e;
    bit   in_txn;
    bit   ack_pending;
    int   cnt;
    int   wt;
    in_txn = 0; ack_pending = 0; cnt = 0; wt = 0;
    forever begin
      @(negedge i_clk);
      if (ack_pending) begin
        ack_pending = 0;
        last_wait = wt;
        if (cur.we) begin
          smem[cur.addr[31:2]] = merge(smem_rd(cur.addr[31:2]), cur.wdata, cur.be);
          pend_wr--;
        end
        if (exp_q.size() == 0) check("unexpected_txn", exp_q.size(), 1);
        else begin
          e = exp_q.pop_front();
          check("txn_we", {31'b0, cur.we}, {31'b0, e.we});
          check("txn_be", {28'b0, cur.be}, {28'b0, e.be});
          check("txn_addr", cur.addr, e.addr);
          if (e.we) check("txn_wdata", cur.wdata, e.wdata);
        end
      end
      i_mem_ack = 1'b0;
      i_mem_rdata = $urandom();
      if (!i_rst_n) in_txn = 0;
      else if (o_mem_req) begin
        if (!in_txn) begin
          in_txn = 1; cnt = 0;
          cur.we = o_mem_we; cur.be = o_mem_be; cur.addr = o_mem_addr; cur.wdata = o_mem_wdata;
          wt = (slave_wait >= 0) ? slave_wait : int'($urandom_range(0, 3));
        end else begin
          check("req_stable_we", {31'b0, o_mem_we}, {31'b0, cur.we});
          check("req_stable_be", {28'b0, o_mem_be}, {28'b0, cur.be});
          check("req_stable_addr", o_mem_addr, cur.addr);
          if (cur.we) check("req_stable_wdata", o_mem_wdata, cur.wdata);
        end
        if (!slave_hold && cnt >= wt) begin
          i_mem_ack = 1'b1;
          i_mem_rdata = smem_rd(cur.addr[31:2]);
          ack_pending = 1;
          in_txn = 0;
        end else cnt++;
      end else begin
        in_txn = 0;
        i_mem_ack = ($urandom_range(0, 3) == 0);
      end
    end
  end

  // One cpu access, called at negedge+1; pre = stall cycles before accept,
  // post = stall cycles after accept (not waited for on buffered stores)
  task automatic cpu_op(input bit rd, input logic [3:0] wr, input logic [31:0] addr,
                        input logic [31:0] wd, output int pre, output int post);
    txn_t        t;
    logic [31:0] exp_rd;
    bit          wait_post;
    i_rd_d = rd; i_wr_d = wr; i_addr_d = addr; i_data_wr_d = wd;
    pre = 0;
    while (!o_clk_ce && pre < BUDGET) begin @(negedge i_clk); #1; pre++; end
    if (!o_clk_ce) check("accept_timeout", {31'b0, o_clk_ce}, 1);
    exp_rd = last_rd;
    wait_post = 1;
    if (wr != 4'h0) begin
      t = '{1'b1, wr, addr & 32'hFFFF_FFFC, wd};
      exp_q.push_back(t);
      pend_wr++;
      rmem[addr[31:2]] = merge(rmem_rd(addr[31:2]), wd, wr);
`ifdef DBUS_WBUF_EN
      wait_post = 0;
`endif
    end else if (rd) begin
      t = '{1'b0, 4'hF, addr & 32'hFFFF_FFFC, 32'h0};
      exp_q.push_back(t);
      exp_rd = rmem_rd(addr[31:2]);
    end
    @(negedge i_clk); #1;
    i_rd_d = 1'b0; i_wr_d = 4'h0;
    post = 0;
    if (wait_post) begin
      while (!o_clk_ce && post < BUDGET) begin @(negedge i_clk); #1; post++; end
      if (!o_clk_ce) check("complete_timeout", {31'b0, o_clk_ce}, 1);
    end
    check((rd && wr == 4'h0) ? "rd_data" : "rd_data_hold", o_data_rd_d, exp_rd);
    last_rd = exp_rd;
  endtask

  task automatic wait_drain();
    int c;
    c = 0;
    while ((exp_q.size() != 0 || !o_clk_ce) && c < BUDGET) begin @(negedge i_clk); #1; c++; end
    if (c >= BUDGET) check("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          pre;
    int          post;
    int          pre5;
    int          post5;
    int          r;
    int          pend0;
    bit          is_wr;
    bit          is_rd;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;

    // Reset state
    repeat (3) @(negedge i_clk);
    #1;
    check("rst_req", {31'b0, o_mem_req}, 0);
    check("rst_we", {31'b0, o_mem_we}, 0);
    check("rst_be", {28'b0, o_mem_be}, 0);
    check("rst_addr", o_mem_addr, 0);
    check("rst_wdata", o_mem_wdata, 0);
    check("rst_rdata", o_data_rd_d, 0);
    check("rst_ce", {31'b0, o_clk_ce}, 1);
    @(negedge i_clk); i_rst_n = 1'b1; #1;

    // Zero-wait read
    smem[30'h40] = 32'hDEADBEEF;
    rmem[30'h40] = 32'hDEADBEEF;
    slave_wait = 0;
    cpu_op(1'b1, 4'h0, 32'h100, 32'h0, pre, post);
    check("t1_pre", pre, 0);
    check("t1_stall", post, 1);
    check("t1_rdata", o_data_rd_d, 32'hDEADBEEF);

    // Unaligned read with 3 wait states
    slave_wait = 3;
    cpu_op(1'b1, 4'h0, 32'h102, 32'h0, pre, post);
    check("t2_stall", post, 4);

    // Read together with write is only a write
    slave_wait = 0;
    cpu_op(1'b1, 4'h1, 32'h104, 32'h0000_00A5, pre, post);
`ifndef DBUS_WBUF_EN
    check("t5_stall", post, 1);
`endif
    wait_drain();
    check("t5_rdata_kept", o_data_rd_d, 32'hDEADBEEF);

`ifdef DBUS_WBUF_EN
    // Back-to-back posted writes against a stalled bus
    slave_hold = 1;
    for (int i = 0; i < 4; i++) begin
      cpu_op(1'b0, 4'hF, 32'h200 + 32'(i * 4), 32'h10 + 32'(i), pre, post);
      check("t3_no_stall", pre, 0);
    end
    fork
      cpu_op(1'b0, 4'hF, 32'h210, 32'h14, pre5, post5);
      begin
        repeat (5) @(negedge i_clk);
        #1;
        check("t3_full_stall", {31'b0, o_clk_ce}, 0);
        slave_hold = 0;
      end
    join
    check("t3_fifth_stalled", {31'b0, pre5 >= 5}, 1);
    wait_drain();

    // Posted write followed by a read of the same word
    slave_wait = 1;
    cpu_op(1'b0, 4'h3, 32'h300, 32'h0000_55AA, pre, post);
    cpu_op(1'b1, 4'h0, 32'h300, 32'h0, pre, post);
    check("t4_rdata", o_data_rd_d, {mem_init(30'hC0) & 32'hFFFF_0000} | 32'h0000_55AA);
    wait_drain();
`endif

    // Reset in the middle of a transaction
    slave_hold = 1;
    slave_wait = 0;
`ifdef DBUS_WBUF_EN
    cpu_op(1'b0, 4'hF, 32'h500, 32'h1234_5678, pre, post);
`endif
    i_rd_d = 1'b1; i_addr_d = 32'h504;
    @(negedge i_clk); #1;
    i_rd_d = 1'b0;
    check("t6_req_before_rst", {31'b0, o_mem_req}, 1);
    #2 i_rst_n = 1'b0;
    #1;
    check("t6_req_in_rst", {31'b0, o_mem_req}, 0);
    check("t6_ce_in_rst", {31'b0, o_clk_ce}, 1);
    check("t6_rdata_in_rst", o_data_rd_d, 0);
    exp_q.delete();
    pend_wr = 0;
    rmem = smem;
    last_rd = '0;
    @(negedge i_clk); i_rst_n = 1'b1; slave_hold = 0; #1;
    repeat (2) begin
      @(negedge i_clk); #1;
      check("t6_fifo_empty", {31'b0, o_mem_req}, 0);
    end
    cpu_op(1'b1, 4'h0, 32'h500, 32'h0, pre, post);
    check("t6_read_stall", post, 1);

    // Randomized mix
    slave_wait = -1;
    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 9);
      a = 32'h400 + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
      d = $urandom();
      be = 4'($urandom_range(1, 15));
      is_wr = (r >= 4);
      is_rd = (r < 4) || (r == 9);
      pend0 = pend_wr;
      cpu_op(is_rd, is_wr ? be : 4'h0, a, d, pre, post);
`ifdef DBUS_WBUF_EN
      if (is_wr && pend0 < int'(DEPTH)) check("rnd_wr_nostall", pre, 0);
      if (!is_wr && pend0 == 0) begin
        check("rnd_rd_pre", pre, 0);
        check("rnd_rd_stall", post, 32'(1 + last_wait));
      end
`else
      check("rnd_pre", pre, 0);
      check("rnd_stall", post, 32'(1 + last_wait));
`endif
      repeat ($urandom_range(0, 2)) begin @(negedge i_clk); #1; end
    end
    wait_drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
